// File: rtl/led_status_driver_pkg.sv
// Shared definitions for the LED status driver.
//
// Purpose: field layout of the 12-bit arbitration result, the display FSM
// state codes, and small decode helpers used when turning a snapshot into
// LED levels.
//
// Result layout: [5:0] IE01, [11:6] IE02. Inside each 6-bit IE field,
// [2:0] are the grant bits of fn0..fn2 and [5:3] the blocked bits.

package led_status_driver_pkg;

  localparam int RESULT_W  = 12;
  localparam int IE01_BASE = 0;
  localparam int IE02_BASE = 6;
  localparam int GRANT_OFS = 0;
  localparam int BLOCK_OFS = 3;
  localparam int FN_COUNT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SHOW = 2'd2
  } led_state_e;

  // Grant wins over blocked on the same function; a blocked-only function
  // follows the blink phase.
  function automatic logic led_level(input logic [RESULT_W-1:0] snap,
                                     input int base, input int fn,
                                     input logic phase);
    return snap[base + GRANT_OFS + fn] | (snap[base + BLOCK_OFS + fn] & phase);
  endfunction

  function automatic logic any_blocked(input logic [RESULT_W-1:0] snap);
    return |{snap[IE02_BASE + BLOCK_OFS +: FN_COUNT],
             snap[IE01_BASE + BLOCK_OFS +: FN_COUNT]};
  endfunction

  function automatic logic any_granted(input logic [RESULT_W-1:0] snap);
    return |{snap[IE02_BASE + GRANT_OFS +: FN_COUNT],
             snap[IE01_BASE + GRANT_OFS +: FN_COUNT]};
  endfunction

endpackage

// File: rtl/led_status_driver_blink_divider.sv
// Blink phase generator for the LED status driver.
//
// Purpose: free-running counter 0..BLINK_DIV-1; the phase output toggles
// each time the counter wraps, so every phase lasts BLINK_DIV cycles.
//
// Ports:
//   CLK    in   system clock
//   RST    in   synchronous active-high reset (counter and phase to 0)
//   phase  out  current blink phase, 0 (off) right after reset

module blink_divider
  import led_status_driver_pkg::*;
#(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic CLK,
  input  logic RST,
  output logic phase
);

  localparam int CNT_W = $clog2(BLINK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Counter wraps at BLINK_DIV-1 and flips the phase on that same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_status_driver.sv
// LED status driver: output end of the priority path.
//
// Purpose: registers the 12-bit arbitration result, holds each displayed
// snapshot for at least HOLD_CYCLES cycles so bouncing inputs do not
// flicker the LEDs, and blinks functions that are blocked without a grant.
// Changes arriving during a hold are not queued; the latest value wins.
//
// Ports:
//   CLK            in   system clock
//   RST            in   synchronous active-high reset
//   result[11:0]   in   arbitration result (IE01 in [5:0], IE02 in [11:6])
//   LED5..LED3     out  IE01 fn0..fn2 status
//   LED2..LED0     out  IE02 fn0..fn2 status
//   LEDRGB_red     out  any blocked bit set in the snapshot
//   LEDRGB_green   out  snapshot is all zero
//   LEDRGB_blue    out  any grant bit set in the snapshot
//   update_pulse   out  one-cycle strobe alongside new output values

module led_status_driver
  import led_status_driver_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_DIV   = 12_500_000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [RESULT_W-1:0] result,
  output logic                LED5,
  output logic                LED4,
  output logic                LED3,
  output logic                LED2,
  output logic                LED1,
  output logic                LED0,
  output logic                LEDRGB_red,
  output logic                LEDRGB_green,
  output logic                LEDRGB_blue,
  output logic                update_pulse
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic [RESULT_W-1:0] in_q;
  logic [RESULT_W-1:0] snap;
  logic [HOLD_W-1:0]   hold_cnt;
  led_state_e          state;
  led_state_e          state_next;
  logic                reload;
  logic                reload_q;
  logic                phase;
  logic [5:0]          led_next;
  logic [5:0]          led_q;
  logic                red_q;
  logic                green_q;
  logic                blue_q;
  logic                pulse_q;

  blink_divider #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .CLK  (CLK),
    .RST  (RST),
    .phase(phase)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_q <= '0;
    end else begin
      in_q <= result;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // HOLD covers exactly the cycles where hold_cnt is non-zero, so a reload
  // is only possible from IDLE or SHOW. A hold of one cycle never enters HOLD.
  always_comb begin
    state_next = state;
    reload     = 1'b0;
    unique case (state)
      ST_IDLE, ST_SHOW: begin
        if (in_q != snap) begin
          reload = 1'b1;
          if (HOLD_CYCLES > 1) begin
            state_next = ST_HOLD;
          end else begin
            state_next = (in_q == '0) ? ST_IDLE : ST_SHOW;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_W'(1)) begin
          state_next = (snap == '0) ? ST_IDLE : ST_SHOW;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // reload_q delays the strobe by one stage so it lines up with the
  // registered outputs that first show the new snapshot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snap     <= '0;
      hold_cnt <= '0;
      reload_q <= 1'b0;
    end else begin
      reload_q <= reload;
      if (reload) begin
        snap     <= in_q;
        hold_cnt <= HOLD_LOAD;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

  // LED5..LED3 map IE01 fn0..fn2 and LED2..LED0 map IE02 fn0..fn2.
  always_comb begin
    led_next = '0;
    for (int fn = 0; fn < FN_COUNT; fn++) begin
      led_next[5 - fn] = led_level(snap, IE01_BASE, fn, phase);
      led_next[2 - fn] = led_level(snap, IE02_BASE, fn, phase);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      led_q   <= '0;
      red_q   <= 1'b0;
      green_q <= 1'b1;
      blue_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      led_q   <= led_next;
      red_q   <= any_blocked(snap);
      green_q <= (snap == '0);
      blue_q  <= any_granted(snap);
      pulse_q <= reload_q;
    end
  end

  // Pin polarity is applied after the registers; the strobe is not a pin LED.
  assign LED5         = led_q[5] ^ ACTIVE_LOW;
  assign LED4         = led_q[4] ^ ACTIVE_LOW;
  assign LED3         = led_q[3] ^ ACTIVE_LOW;
  assign LED2         = led_q[2] ^ ACTIVE_LOW;
  assign LED1         = led_q[1] ^ ACTIVE_LOW;
  assign LED0         = led_q[0] ^ ACTIVE_LOW;
  assign LEDRGB_red   = red_q ^ ACTIVE_LOW;
  assign LEDRGB_green = green_q ^ ACTIVE_LOW;
  assign LEDRGB_blue  = blue_q ^ ACTIVE_LOW;
  assign update_pulse = pulse_q;

endmodule

// File: tb/tb_led_status_driver.sv
// Testbench for led_status_driver (HOLD_CYCLES=4, BLINK_DIV=2, ACTIVE_LOW=0).
//
// Directed steps followed by random traffic; expected values come from a
// timestamp-based reference model of the display rules.

module tb_led_status_driver;

  localparam int HOLD = 4;
  localparam int BDIV = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [11:0] result;
  logic        LED5, LED4, LED3, LED2, LED1, LED0;
  logic        LEDRGB_red, LEDRGB_green, LEDRGB_blue;
  logic        update_pulse;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: value presented to the snapshot stage, current snapshot,
  // edges since reset, first edge index at which a new snapshot may be taken,
  // and whether the previous edge took a snapshot.
  logic [11:0] m_in;
  logic [11:0] m_snap;
  int          m_k;
  int          m_free_at;
  logic        m_took_prev;

  logic [5:0]  e_led;
  logic        e_red, e_green, e_blue, e_pulse;

  led_status_driver #(
    .HOLD_CYCLES(HOLD),
    .BLINK_DIV  (BDIV),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .result      (result),
    .LED5        (LED5),
    .LED4        (LED4),
    .LED3        (LED3),
    .LED2        (LED2),
    .LED1        (LED1),
    .LED0        (LED0),
    .LEDRGB_red  (LEDRGB_red),
    .LEDRGB_green(LEDRGB_green),
    .LEDRGB_blue (LEDRGB_blue),
    .update_pulse(update_pulse)
  );

  always #5 CLK = ~CLK;

  // Advances the model by one clock edge using the inputs the DUT sampled.
  task automatic modelEdge(input logic rst_v, input logic [11:0] res_v);
    logic ph;
    logic take;
    if (rst_v) begin
      m_in        = '0;
      m_snap      = '0;
      m_k         = 0;
      m_free_at   = 0;
      m_took_prev = 1'b0;
      e_led       = '0;
      e_red       = 1'b0;
      e_green     = 1'b1;
      e_blue      = 1'b0;
      e_pulse     = 1'b0;
    end else begin
      ph = ((m_k / BDIV) % 2) == 1;
      for (int fn = 0; fn < 3; fn++) begin
        e_led[5 - fn] = m_snap[fn] | (m_snap[3 + fn] & ph);
        e_led[2 - fn] = m_snap[6 + fn] | (m_snap[9 + fn] & ph);
      end
      e_red   = |{m_snap[11:9], m_snap[5:3]};
      e_blue  = |{m_snap[8:6], m_snap[2:0]};
      e_green = (m_snap == 12'h000);
      e_pulse = m_took_prev;
      take = (m_in != m_snap) && (m_k >= m_free_at);
      if (take) begin
        m_snap    = m_in;
        m_free_at = m_k + HOLD;
      end
      m_took_prev = take;
      m_in        = res_v;
      m_k++;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [5:0] leds;
    logic [2:0] rgb;
    logic [2:0] e_rgb;
    leds  = {LED5, LED4, LED3, LED2, LED1, LED0};
    rgb   = {LEDRGB_red, LEDRGB_green, LEDRGB_blue};
    e_rgb = {e_red, e_green, e_blue};
    n_cmp++;
    assert (leds === e_led) else begin
      n_err++;
      $error("[TB] FAIL %s leds observed=%b expected=%b", tag, leds, e_led);
    end
    n_cmp++;
    assert (rgb === e_rgb) else begin
      n_err++;
      $error("[TB] FAIL %s rgb(r,g,b) observed=%b expected=%b", tag, rgb, e_rgb);
    end
    n_cmp++;
    assert (update_pulse === e_pulse) else begin
      n_err++;
      $error("[TB] FAIL %s update_pulse observed=%b expected=%b", tag, update_pulse, e_pulse);
    end
  endtask

  // Drives one cycle of inputs, clocks the DUT and model, then checks #1 later.
  task automatic applyStimulus(input logic rst_v, input logic [11:0] res_v, input string tag);
    RST    = rst_v;
    result = res_v;
    @(posedge CLK);
    modelEdge(rst_v, res_v);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkDirect(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    logic [11:0] cur;
    logic        r;
    RST    = 1'b1;
    result = '0;

    // Reset held for three cycles with an idle result.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 12'h000, $sformatf("reset%0d", i));
    checkDirect("reset_direct", {LED5, LED4, LED3, LED2, LED1, LED0, LEDRGB_red, LEDRGB_green, LEDRGB_blue},
                9'b000000_010);

    // First grant shows three edges after it is applied, with a pulse.
    applyStimulus(1'b0, 12'h001, "grant_a");
    applyStimulus(1'b0, 12'h001, "grant_b");
    applyStimulus(1'b0, 12'h040, "grant_c");
    checkDirect("first_show", {LED5, LED2, LEDRGB_red, LEDRGB_green, LEDRGB_blue, update_pulse, 3'b000},
                {6'b10_0011, 3'b000});

    // The new value waits out the hold, then replaces the display.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 12'h040, $sformatf("hold%0d", i));
    checkDirect("after_hold", {LED5, LED2, update_pulse, LEDRGB_blue, 5'b00000}, {4'b0111, 5'b00000});

    // Blocked-only fn0 blinks; grant plus block is steady; all-blocked blinks together.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 12'h008, $sformatf("blink%0d", i));
    for (int i = 0; i < 8; i++)  applyStimulus(1'b0, 12'h009, $sformatf("grantblk%0d", i));
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 12'hE38, $sformatf("allblk%0d", i));

    // Reset in the middle of a hold, then an immediate new result.
    applyStimulus(1'b0, 12'h001, "prerst_a");
    applyStimulus(1'b0, 12'h001, "prerst_b");
    applyStimulus(1'b0, 12'h001, "prerst_c");
    applyStimulus(1'b1, 12'h001, "midhold_rst");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 12'h080, $sformatf("postrst%0d", i));
    checkDirect("no_stall", {LED5, LED4, LED3, LED2, LED1, LED0, update_pulse, 2'b00}, 9'b000010_100);

    // Random traffic with sparse changes and occasional resets.
    cur = 12'($urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cur = 12'($urandom);
      r = ($urandom_range(0, 59) == 0);
      applyStimulus(r, cur, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
